obuf_tag_sequencer: RTL and testbench

//  Initiator side of the OBUF double-buffer tag protocol. Takes block requests from the layer

---
 rtl/obuf_tag_pkg.sv | 21 ++
 rtl/obuf_tag_sequencer_ptr.sv | 25 ++
 rtl/obuf_tag_sequencer.sv | 150 +++++++++++++++
 tb/tb_obuf_tag_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_tag_pkg.sv
// Shared types and helpers for the OBUF tag sequencer: sequencer states and
// the wrapping tag-pointer increment.
package obuf_tag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  localparam int unsigned PTR_MAX_W = 8;

  // num_tags is a power of two, so masking gives the modulo wrap
  function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                    input int unsigned num_tags);
    logic [PTR_MAX_W-1:0] mask;
    mask = PTR_MAX_W'(num_tags - 1);
    return (ptr + PTR_MAX_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/obuf_tag_sequencer_ptr.sv
// Wrapping round-robin tag pointer with synchronous clear and advance enable.
module tag_ptr_rr
  import obuf_tag_pkg::*;
#(
  parameter int unsigned NUM_TAGS = 2,
  parameter int unsigned TAG_W    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [TAG_W-1:0] ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= TAG_W'(ptr_inc(PTR_MAX_W'(ptr), NUM_TAGS));
    end
  end

endmodule

// File: rtl/obuf_tag_sequencer.sv
// Initiator side of the OBUF double-buffer tag protocol: allocates tags round-robin,
// issues req/reuse/flush pulses, tracks stage pointers and signals layer completion.
module obuf_tag_sequencer
  import obuf_tag_pkg::*;
#(
  parameter int unsigned NUM_TAGS      = 2,
  parameter int unsigned TAG_W         = 1,
  parameter int unsigned STORE_ENABLED = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                layer_done,
  input  logic                block_req,
  output logic                block_ready,
  input  logic                block_reuse,
  input  logic                block_flush,
  input  logic                block_last,
  output logic                seq_error,
  output logic [NUM_TAGS-1:0] tag_req,
  output logic [NUM_TAGS-1:0] tag_reuse,
  output logic [NUM_TAGS-1:0] tag_flush,
  input  logic [NUM_TAGS-1:0] tag_ready,
  input  logic [NUM_TAGS-1:0] next_compute_tag,
  input  logic [NUM_TAGS-1:0] ldmem_tag_ready,
  input  logic                ldmem_tag_done,
  input  logic                stmem_tag_done,
  output logic [TAG_W-1:0]    ldmem_tag,
  output logic [TAG_W-1:0]    compute_tag,
  output logic [TAG_W-1:0]    stmem_tag,
  output logic                ldmem_ready,
  output logic                busy
);

  localparam int unsigned CNT_W = TAG_W + 1;

  seq_state_e          state_q, state_d;
  logic [TAG_W-1:0]    alloc_ptr, last_ptr;
  logic                have_tag;
  logic [NUM_TAGS-1:0] tag_ready_q, ready_rise;
  logic [CNT_W-1:0]    outstanding, outstanding_d;
  logic                in_run, in_idle, start_go;
  logic                req_go, reuse_go, flush_go, block_any, err_evt, cnt_err;
  int                  cnt_sum;

  assign in_run      = (state_q == ST_RUN);
  assign in_idle     = (state_q == ST_IDLE);
  assign start_go    = in_idle & start;
  assign block_ready = in_run & tag_ready[alloc_ptr];
  assign block_any   = block_req | block_reuse | block_flush | block_last;
  assign req_go      = block_req & block_ready;
  assign reuse_go    = in_run & block_reuse & have_tag & ~req_go;
  assign flush_go    = in_run & block_flush & have_tag;
  assign err_evt     = (~in_run & block_any)
                     | (in_run & block_reuse & (~have_tag | req_go))
                     | (in_run & block_flush & ~have_tag)
                     | cnt_err;

  assign ldmem_ready = ldmem_tag_ready[ldmem_tag];
  assign busy        = (outstanding != '0) | ~in_idle;
  assign ready_rise  = tag_ready & ~tag_ready_q;

  always_comb begin
    state_d    = state_q;
    layer_done = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (flush_go & block_last) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if ((outstanding == '0) && (&tag_ready)) begin
          state_d    = ST_IDLE;
          layer_done = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Each freed tag retires one outstanding block; out-of-range results saturate and flag an error
  always_comb begin
    cnt_sum       = int'(outstanding) + int'(req_go) - $countones(ready_rise);
    cnt_err       = 1'b0;
    outstanding_d = CNT_W'(cnt_sum);
    if (cnt_sum < 0) begin
      cnt_err       = 1'b1;
      outstanding_d = '0;
    end else if (cnt_sum > int'(NUM_TAGS)) begin
      cnt_err       = 1'b1;
      outstanding_d = CNT_W'(NUM_TAGS);
    end
  end

  // Tags are free coming out of reset, so the edge-detect copy starts all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      last_ptr    <= '0;
      have_tag    <= 1'b0;
      outstanding <= '0;
      tag_ready_q <= '1;
      seq_error   <= 1'b0;
      tag_req     <= '0;
      tag_reuse   <= '0;
      tag_flush   <= '0;
    end else begin
      state_q     <= state_d;
      tag_ready_q <= tag_ready;
      outstanding <= outstanding_d;
      tag_req     <= req_go   ? (NUM_TAGS'(1) << alloc_ptr) : '0;
      tag_reuse   <= reuse_go ? (NUM_TAGS'(1) << last_ptr)  : '0;
      tag_flush   <= flush_go ? (NUM_TAGS'(1) << last_ptr)  : '0;
      if (start_go) begin
        last_ptr  <= '0;
        have_tag  <= 1'b0;
        seq_error <= 1'b0;
      end else begin
        seq_error <= seq_error | err_evt;
        if (req_go) begin
          last_ptr <= alloc_ptr;
          have_tag <= 1'b1;
        end
      end
    end
  end

  tag_ptr_rr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_alloc_ptr (
    .clk(clk), .reset(reset), .clear(start_go), .advance(req_go), .ptr(alloc_ptr)
  );

  tag_ptr_rr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_ldmem_ptr (
    .clk(clk), .reset(reset), .clear(start_go),
    .advance(ldmem_tag_done & ldmem_ready), .ptr(ldmem_tag)
  );

  tag_ptr_rr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_compute_ptr (
    .clk(clk), .reset(reset), .clear(start_go),
    .advance(next_compute_tag[compute_tag]), .ptr(compute_tag)
  );

  // Without a store stage a tag is released by compute, so the store pointer simply follows it
  if (STORE_ENABLED != 0) begin : g_store
    tag_ptr_rr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_stmem_ptr (
      .clk(clk), .reset(reset), .clear(start_go),
      .advance(stmem_tag_done), .ptr(stmem_tag)
    );
  end else begin : g_no_store
    assign stmem_tag = compute_tag;
  end

endmodule

// File: tb/tb_obuf_tag_sequencer.sv
// Self-checking bench for obuf_tag_sequencer: directed protocol scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_obuf_tag_sequencer;

  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          reset, start, block_req, block_reuse, block_flush, block_last;
  logic [NT-1:0] next_compute_tag, ldmem_tag_ready, tag_busy, tag_ready;
  logic          ldmem_tag_done, stmem_tag_done;
  logic          layer_done, block_ready, seq_error, ldmem_ready, busy;
  logic [NT-1:0] tag_req, tag_reuse, tag_flush;
  logic [0:0]    ldmem_tag, compute_tag, stmem_tag;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  bit            m_run, m_drain, m_have, m_err;
  int            m_alloc, m_last, m_comp, m_ld, m_st, m_outst;
  int            m_req, m_reuse, m_flush;
  logic [NT-1:0] m_prev_ready;

  always #5 clk = ~clk;

  // Stub tag FSMs: a tag is FREE unless it has been requested and not yet released
  assign tag_ready = ~tag_busy;

  obuf_tag_sequencer #(.NUM_TAGS(NT), .TAG_W(1), .STORE_ENABLED(1)) dut (
    .clk(clk), .reset(reset), .start(start), .layer_done(layer_done),
    .block_req(block_req), .block_ready(block_ready), .block_reuse(block_reuse),
    .block_flush(block_flush), .block_last(block_last), .seq_error(seq_error),
    .tag_req(tag_req), .tag_reuse(tag_reuse), .tag_flush(tag_flush),
    .tag_ready(tag_ready), .next_compute_tag(next_compute_tag),
    .ldmem_tag_ready(ldmem_tag_ready), .ldmem_tag_done(ldmem_tag_done),
    .stmem_tag_done(stmem_tag_done), .ldmem_tag(ldmem_tag), .compute_tag(compute_tag),
    .stmem_tag(stmem_tag), .ldmem_ready(ldmem_ready), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_run = 0; m_drain = 0; m_have = 0; m_err = 0;
    m_alloc = 0; m_last = 0; m_comp = 0; m_ld = 0; m_st = 0; m_outst = 0;
    m_req = 0; m_reuse = 0; m_flush = 0;
    m_prev_ready = '1;
  endtask

  // Advance the model by one clock using the inputs held during the current cycle
  task automatic modelStep();
    bit acc, err_evt, finish, start_go;
    int rises, sum, n_comp, n_ld, n_st;
    if (!reset) begin
      modelReset();
      return;
    end
    acc = m_run && block_req && tag_ready[m_alloc];
    err_evt = 0;
    m_req = 0; m_reuse = 0; m_flush = 0;
    if (m_run) begin
      if (acc) m_req = 1 << m_alloc;
      if (block_flush) begin
        if (m_have) m_flush = 1 << m_last;
        else err_evt = 1;
      end
      if (block_reuse) begin
        if (m_have && !acc) m_reuse = 1 << m_last;
        else err_evt = 1;
      end
    end else if (block_req || block_reuse || block_flush || block_last) begin
      err_evt = 1;
    end
    rises = $countones(tag_ready & ~m_prev_ready);
    sum = m_outst + (acc ? 1 : 0) - rises;
    if (sum < 0) begin sum = 0; err_evt = 1; end
    if (sum > NT) begin sum = NT; err_evt = 1; end
    finish   = m_drain && (m_outst == 0) && (tag_ready == '1);
    start_go = !m_run && !m_drain && start;
    n_comp = next_compute_tag[m_comp] ? (m_comp + 1) % NT : m_comp;
    n_ld   = (ldmem_tag_done && ldmem_tag_ready[m_ld]) ? (m_ld + 1) % NT : m_ld;
    n_st   = stmem_tag_done ? (m_st + 1) % NT : m_st;
    if (m_run && block_flush && block_last && m_have) begin
      m_run = 0; m_drain = 1;
    end else if (finish) begin
      m_drain = 0;
    end
    if (start_go) begin
      m_run = 1; m_alloc = 0; m_last = 0; m_have = 0; m_err = 0;
      m_comp = 0; m_ld = 0; m_st = 0;
    end else begin
      m_err = m_err || err_evt;
      if (acc) begin
        m_last = m_alloc; m_alloc = (m_alloc + 1) % NT; m_have = 1;
      end
      m_comp = n_comp; m_ld = n_ld; m_st = n_st;
    end
    m_outst = sum;
    m_prev_ready = tag_ready;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("tag_req", tag_req, m_req);
      checkOutput("tag_reuse", tag_reuse, m_reuse);
      checkOutput("tag_flush", tag_flush, m_flush);
      checkOutput("seq_error", seq_error, m_err);
      checkOutput("block_ready", block_ready, (m_run && tag_ready[m_alloc]) ? 1 : 0);
      checkOutput("layer_done", layer_done,
                  (m_drain && m_outst == 0 && tag_ready == '1) ? 1 : 0);
      checkOutput("busy", busy, (m_outst != 0 || m_run || m_drain) ? 1 : 0);
      checkOutput("compute_tag", compute_tag, m_comp);
      checkOutput("ldmem_tag", ldmem_tag, m_ld);
      checkOutput("stmem_tag", stmem_tag, m_st);
      checkOutput("ldmem_ready", ldmem_ready, ldmem_tag_ready[m_ld]);
    end
  end

  task automatic clearInputs();
    start = 0; block_req = 0; block_reuse = 0; block_flush = 0; block_last = 0;
    next_compute_tag = '0; ldmem_tag_done = 0; stmem_tag_done = 0;
  endtask

  // One clock: model follows the edge, then the stub tags react to any new request
  task automatic applyStimulus();
    @(negedge clk);
    #1;
    modelStep();
    @(posedge clk);
    #1;
    tag_busy = tag_busy | tag_req;
    #1;
  endtask

  initial begin
    logic [NT-1:0] cand;
    reset = 0;
    clearInputs();
    tag_busy = '0;
    ldmem_tag_ready = '0;
    modelReset();
    check_en = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("rst_tag_req", tag_req, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_block_ready", block_ready, 0);
    reset = 1;
    applyStimulus();

    start = 1; applyStimulus(); start = 0;
    block_req = 1;
    checkOutput("t2_ready_first", block_ready, 1);
    applyStimulus();
    checkOutput("t2_req_tag0", tag_req, 2'b01);
    applyStimulus();
    checkOutput("t2_req_tag1", tag_req, 2'b10);
    checkOutput("t2_wait_ready", block_ready, 0);
    applyStimulus();
    checkOutput("t2_held_no_req", tag_req, 0);
    tag_busy[0] = 0;
    applyStimulus();
    block_req = 0;
    checkOutput("t2_req_wrap", tag_req, 2'b01);

    tag_busy[1] = 0;
    block_req = 1; block_flush = 1;
    applyStimulus();
    block_req = 0; block_flush = 0;
    checkOutput("t3_flush_old", tag_flush, 2'b01);
    checkOutput("t3_req_new", tag_req, 2'b10);

    block_reuse = 1; next_compute_tag = 2'b01;
    applyStimulus();
    checkOutput("t4_reuse1", tag_reuse, 2'b10);
    checkOutput("t4_compute1", compute_tag, 1);
    next_compute_tag = 2'b10;
    applyStimulus();
    checkOutput("t4_reuse2", tag_reuse, 2'b10);
    checkOutput("t4_compute0", compute_tag, 0);
    block_reuse = 0; next_compute_tag = '0; block_flush = 1;
    applyStimulus();
    block_flush = 0;
    checkOutput("t4_flush", tag_flush, 2'b10);
    checkOutput("t4_no_err", seq_error, 0);

    block_flush = 1; block_last = 1;
    applyStimulus();
    block_flush = 0; block_last = 0;
    checkOutput("t6_final_flush", tag_flush, 2'b10);
    checkOutput("t6_drain_no_ready", block_ready, 0);
    stmem_tag_done = 1;
    applyStimulus();
    checkOutput("t6_stmem1", stmem_tag, 1);
    applyStimulus();
    stmem_tag_done = 0;
    checkOutput("t6_stmem0", stmem_tag, 0);
    tag_busy[0] = 0;
    applyStimulus();
    checkOutput("t6_not_done_yet", layer_done, 0);
    tag_busy[1] = 0;
    applyStimulus();
    checkOutput("t6_layer_done", layer_done, 1);
    applyStimulus();
    checkOutput("t6_done_pulse_end", layer_done, 0);
    checkOutput("t6_idle_busy", busy, 0);

    start = 1; applyStimulus(); start = 0;
    block_reuse = 1;
    applyStimulus();
    block_reuse = 0;
    checkOutput("t5_reuse_no_tag", tag_reuse, 0);
    checkOutput("t5_err_set", seq_error, 1);
    block_req = 1; block_reuse = 1;
    applyStimulus();
    block_req = 0; block_reuse = 0;
    checkOutput("t5_req_wins", tag_req, 2'b01);
    checkOutput("t5_reuse_dropped", tag_reuse, 0);
    checkOutput("t5_err_sticky", seq_error, 1);

    reset = 0; tag_busy = '0; modelReset();
    #1;
    checkOutput("t1_req_cleared", tag_req, 0);
    checkOutput("t1_err_cleared", seq_error, 0);
    checkOutput("t1_busy_cleared", busy, 0);
    repeat (2) applyStimulus();
    reset = 1;
    repeat (3) begin
      applyStimulus();
      checkOutput("t1_no_late_pulse", tag_req, 0);
    end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      clearInputs();
      if (!reset) begin
        reset = 1;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 0; tag_busy = '0; modelReset();
      end
      if (reset) begin
        start            = ($urandom_range(0, 19) == 0);
        block_req        = ($urandom_range(0, 4) < 2);
        block_reuse      = ($urandom_range(0, 9) == 0);
        block_flush      = ($urandom_range(0, 9) == 0);
        block_last       = block_flush && ($urandom_range(0, 3) == 0);
        next_compute_tag = NT'($urandom_range(0, 3));
        ldmem_tag_ready  = NT'($urandom_range(0, 3));
        ldmem_tag_done   = ($urandom_range(0, 2) == 0);
        stmem_tag_done   = ($urandom_range(0, 3) == 0);
        cand = tag_busy & ~tag_req;
        if (cand != '0 && $urandom_range(0, 2) == 0) begin
          if (cand[0] && (!cand[1] || $urandom_range(0, 1) == 0)) tag_busy[0] = 0;
          else tag_busy[1] = 0;
        end else if ($urandom_range(0, 199) == 0) begin
          tag_busy[$urandom_range(0, 1)] = 1;
        end
      end
      applyStimulus();
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
